enc_scheduler: RTL and testbench
================================

Name: enc_scheduler

Overview:
- Sequences the RS encoder datapath, which carries ENC_SYM_NUM symbol lanes per beat.
- Codewords are packed back-to-back with no gaps, so one beat may hold the tail of one codeword and the head of the next.
- Per beat, the block tracks each lane's position within its codeword and classifies every lane as message or parity.
- It emits start-of-codeword/end-of-codeword (SOP/EOP) lane markers and a message-symbol count. The upstream gearbox and the parity LFSR are driven from these.

Parameters:
- RS_COD_LEN, 544, codeword length N in symbols.
- RS_MSG_LEN, 514, message length K in symbols; must satisfy K < N.
- ENC_SYM_NUM, 16, lanes per beat S; must satisfy 1 <= S <= N.
- CW_CNT_W, 16, codeword counter width; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- sch_ready  in  1  datapath accepts the current beat
- sch_valid  out  1  beat descriptor valid
- sch_clr  out  1  clear datapath/LFSR state
- sch_pos  out  $clog2(N)  codeword position of lane 0
- sch_msg_mask  out  S  bit i=1: lane i carries a message symbol
- sch_msg_cnt  out  $clog2(S+1)  popcount of sch_msg_mask
- sch_sop  out  1  some lane in this beat has position 0
- sch_sop_lane  out  $clog2(S) (min 1)  index of that lane
- sch_eop  out  1  some lane in this beat has position N-1
- sch_eop_lane  out  $clog2(S) (min 1)  index of that lane
- sch_cw_cnt  out  CW_CNT_W  completed codewords (ENC_SCH_CNT_EN only)

Behaviour:
- Single clock domain. Reset is synchronous, active-low, on rst_n sampled at posedge clk.
- FSM with shared enum SCH_PHASE:
  - SCH_IDL, SCH_PRE, SCH_WOR.
  - Reset forces SCH_IDL.
  - IDL goes to PRE after one cycle; PRE goes to WOR after one cycle; WOR stays in WOR.
  - Any illegal encoding returns to IDL.
- pos register:
  - Reset value 0; held at 0 in IDL and PRE.
  - In WOR it advances only when sch_valid && sch_ready.
  - Next pos = (pos+S >= N) ? pos+S-N : pos+S. Always in 0..N-1.
  - Compute in width $clog2(N+S) to avoid overflow.
- Lane i position: q_i = pos+i, minus N if pos+i >= N.
  - message if q_i < K, else parity.
  - sop lane: q_i == 0. eop lane: q_i == N-1.
  - At most one of each per beat, because S <= N.
- Outputs are decoded combinationally from the registered pos and phase. No pipeline: descriptor latency is 0 from pos.
- sch_valid = (phase==WOR). sch_clr = (phase==PRE), high for exactly one cycle.
- When sch_valid=0:
  - sch_msg_mask, sch_msg_cnt, sch_sop, sch_eop and the lane indices all read 0.
  - sch_pos reads 0.
- Reset values: every output 0.
- First valid beat appears on the 2nd clock after rst_n rises: one IDL cycle, one PRE cycle, then WOR with pos=0 and sop at lane 0.
- Stall: while sch_ready=0, pos and every output hold stable. sch_valid stays 1 and is never withdrawn.
- A beat containing only parity has sch_msg_cnt=0 and is still presented. The upstream gearbox supplies nothing on that beat.
- Reset mid-operation: on the next edge, phase=IDL and pos=0. The partial codeword is dropped with no EOP, and the PRE clear is repeated.
- Simultaneous sop and eop in one beat (wrap): sch_eop_lane = sch_sop_lane-1.

Optional Feature:
- Macro ENC_SCH_CNT_EN.
- Defined:
  - sch_cw_cnt exists, reset to 0 and cleared in PRE.
  - It increments by 1 on each accepted beat with sch_eop=1, wrapping modulo 2^CW_CNT_W.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- encoder.vh / shared package holds:
  - the SCH_PHASE typedef;
  - RS_COD_LEN, RS_MSG_LEN, ENC_SYM_NUM defaults;
  - derived widths: position width, count width, lane-index width.
- One sub-module, enc_sch_lane_dec: per-lane classifier.
  - Inputs: pos and lane index.
  - Outputs: msg, sop, eop flags.
  - Instantiated S times via generate.
  - The top level OR-reduces the flags, encodes the lane indices and computes the popcount.

Test Plan (N=15, K=11, S=4):
- Reset release, sch_ready=1 -> cycle0 IDL; cycle1 sch_clr=1; cycle2 sch_valid=1, pos=0, mask=4'b1111, cnt=4, sop lane0.
- Free run -> pos sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11, then back to 0; period 15 beats = 4 codewords.
- pos=8 -> mask=4'b0111, cnt=3, eop=0. pos=12 -> mask=4'b1000, cnt=1, eop lane2, sop lane3.
- pos=11 -> mask=4'b0000, cnt=0, eop lane3, sop=0; the beat is still accepted.
- sch_ready=0 for 5 cycles at pos=12 -> all outputs frozen; on release pos advances to 1.
- rst_n=0 at pos=9 -> next cycle sch_valid=0 and all outputs 0. With ENC_SCH_CNT_EN defined, the 60-beat run gives sch_cw_cnt=16, and the counter returns to 0 after reset/PRE.

Source files
------------

// File: rtl/enc_scheduler_pkg.sv
// enc_scheduler_pkg: shared phase enum, default RS geometry and derived width helpers for the encoder scheduler.
package enc_scheduler_pkg;
  typedef enum logic [1:0] {SCH_IDL = 2'd0, SCH_PRE = 2'd1, SCH_WOR = 2'd2} sch_phase_t;
  localparam int DEF_COD_LEN = 544;
  localparam int DEF_MSG_LEN = 514;
  localparam int DEF_SYM_NUM = 16;
  function automatic int pos_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int sum_w(input int n, input int s);
    return $clog2(n + s);
  endfunction
  function automatic int cnt_w(input int s);
    return $clog2(s + 1);
  endfunction
  function automatic int lane_w(input int s);
    return s > 1 ? $clog2(s) : 1;
  endfunction
endpackage

// File: rtl/enc_sch_lane_dec.sv
// enc_sch_lane_dec: classifies one lane as message/parity and flags codeword start/end from lane 0 position.
module enc_sch_lane_dec
  import enc_scheduler_pkg::*;
#(
  parameter int RS_COD_LEN = DEF_COD_LEN,
  parameter int RS_MSG_LEN = DEF_MSG_LEN,
  parameter int ENC_SYM_NUM = DEF_SYM_NUM,
  localparam int PW = pos_w(RS_COD_LEN),
  localparam int EW = sum_w(RS_COD_LEN, ENC_SYM_NUM),
  localparam int LW = lane_w(ENC_SYM_NUM)
) (
  input  logic [PW-1:0] pos,
  input  logic [LW-1:0] lane,
  output logic          msg,
  output logic          sop,
  output logic          eop
);
  logic [EW-1:0] sum, q;
  assign sum = EW'(pos) + EW'(lane);
  assign q = sum >= EW'(RS_COD_LEN) ? sum - EW'(RS_COD_LEN) : sum;
  assign msg = q < EW'(RS_MSG_LEN);
  assign sop = q == '0;
  assign eop = q == EW'(RS_COD_LEN - 1);
endmodule

// File: rtl/enc_scheduler.sv
// enc_scheduler: per-beat lane descriptor generator for the RS encoder (back-to-back codewords).
// Optional completed-codeword counter sch_cw_cnt is compiled in with ENC_SCH_CNT_EN.
module enc_scheduler
  import enc_scheduler_pkg::*;
#(
  parameter int RS_COD_LEN = DEF_COD_LEN,
  parameter int RS_MSG_LEN = DEF_MSG_LEN,
  parameter int ENC_SYM_NUM = DEF_SYM_NUM,
  parameter int CW_CNT_W = 16,
  localparam int PW = pos_w(RS_COD_LEN),
  localparam int EW = sum_w(RS_COD_LEN, ENC_SYM_NUM),
  localparam int CW = cnt_w(ENC_SYM_NUM),
  localparam int LW = lane_w(ENC_SYM_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sch_ready,
  output logic                   sch_valid,
  output logic                   sch_clr,
  output logic [PW-1:0]          sch_pos,
  output logic [ENC_SYM_NUM-1:0] sch_msg_mask,
  output logic [CW-1:0]          sch_msg_cnt,
  output logic                   sch_sop,
  output logic [LW-1:0]          sch_sop_lane,
  output logic                   sch_eop,
  output logic [LW-1:0]          sch_eop_lane
`ifdef ENC_SCH_CNT_EN
  ,
  output logic [CW_CNT_W-1:0]    sch_cw_cnt
`endif
);
  sch_phase_t phase, phase_nxt;
  logic [PW-1:0] pos;
  logic [EW-1:0] pos_sum;
  logic [ENC_SYM_NUM-1:0] msg_v, sop_v, eop_v;
  always_ff @(posedge clk)
    phase <= !rst_n ? SCH_IDL : phase_nxt;
  always_comb
    phase_nxt = phase == SCH_IDL ? SCH_PRE :
                (phase == SCH_PRE || phase == SCH_WOR) ? SCH_WOR : SCH_IDL;
  assign pos_sum = EW'(pos) + EW'(ENC_SYM_NUM);
  always_ff @(posedge clk)
    if (!rst_n || phase != SCH_WOR) pos <= '0;
    else if (sch_ready) pos <= pos_sum >= EW'(RS_COD_LEN) ? PW'(pos_sum - EW'(RS_COD_LEN)) : PW'(pos_sum);
  for (genvar i = 0; i < ENC_SYM_NUM; i++) begin : g_lane
    enc_sch_lane_dec #(
      .RS_COD_LEN (RS_COD_LEN),
      .RS_MSG_LEN (RS_MSG_LEN),
      .ENC_SYM_NUM(ENC_SYM_NUM)
    ) u_dec (
      .pos (pos),
      .lane(LW'(i)),
      .msg (msg_v[i]),
      .sop (sop_v[i]),
      .eop (eop_v[i])
    );
  end
  // S <= N guarantees at most one sop and one eop lane, so a plain priority scan encodes them
  always_comb begin
    sch_valid = phase == SCH_WOR;
    sch_clr = phase == SCH_PRE;
    sch_pos = sch_valid ? pos : '0;
    sch_msg_mask = sch_valid ? msg_v : '0;
    sch_msg_cnt = '0;
    sch_sop = 1'b0;
    sch_sop_lane = '0;
    sch_eop = 1'b0;
    sch_eop_lane = '0;
    for (int i = 0; i < ENC_SYM_NUM; i++) begin
      sch_msg_cnt = sch_msg_cnt + CW'(sch_msg_mask[i]);
      if (sch_valid && sop_v[i]) begin
        sch_sop = 1'b1;
        sch_sop_lane = LW'(i);
      end
      if (sch_valid && eop_v[i]) begin
        sch_eop = 1'b1;
        sch_eop_lane = LW'(i);
      end
    end
  end
`ifdef ENC_SCH_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n || sch_clr) sch_cw_cnt <= '0;
    else if (sch_valid && sch_ready && sch_eop) sch_cw_cnt <= sch_cw_cnt + CW_CNT_W'(1);
`else
  logic [CW_CNT_W-1:0] unused_cw;
  assign unused_cw = '0;
`endif
endmodule

// File: tb/tb_enc_scheduler.sv
// tb_enc_scheduler: randomized and directed bench for enc_scheduler with N=15, K=11, S=4 against a modulo-arithmetic model.
module tb_enc_scheduler;
  localparam int N = 15, K = 11, S = 4;
  logic clk = 1'b0, rst_n = 1'b0, sch_ready = 1'b0;
  logic sch_valid, sch_clr, sch_sop, sch_eop;
  logic [3:0] sch_pos, sch_msg_mask;
  logic [2:0] sch_msg_cnt;
  logic [1:0] sch_sop_lane, sch_eop_lane;
`ifdef ENC_SCH_CNT_EN
  logic [15:0] sch_cw_cnt;
`endif
  int errs = 0, checks = 0;
  int m_phase = 0, m_pos = 0, m_cnt = 0;
  int seq [15] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11};
  always #5 clk = ~clk;
  enc_scheduler #(.RS_COD_LEN(N), .RS_MSG_LEN(K), .ENC_SYM_NUM(S), .CW_CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sch_ready   (sch_ready),
    .sch_valid   (sch_valid),
    .sch_clr     (sch_clr),
    .sch_pos     (sch_pos),
    .sch_msg_mask(sch_msg_mask),
    .sch_msg_cnt (sch_msg_cnt),
    .sch_sop     (sch_sop),
    .sch_sop_lane(sch_sop_lane),
    .sch_eop     (sch_eop),
    .sch_eop_lane(sch_eop_lane)
`ifdef ENC_SCH_CNT_EN
    ,
    .sch_cw_cnt  (sch_cw_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit has_eop(input int p);
    for (int i = 0; i < S; i++) if ((p + i) % N == N - 1) return 1'b1;
    return 1'b0;
  endfunction
  task automatic check_all();
    int emask, ecnt, esop, eslane, eeop, eelane, q;
    bit ev;
    ev = m_phase == 2;
    emask = 0; ecnt = 0; esop = 0; eslane = 0; eeop = 0; eelane = 0;
    if (ev)
      for (int i = 0; i < S; i++) begin
        q = (m_pos + i) % N;
        if (q < K) begin
          emask |= 1 << i;
          ecnt++;
        end
        if (q == 0) begin
          esop = 1;
          eslane = i;
        end
        if (q == N - 1) begin
          eeop = 1;
          eelane = i;
        end
      end
    chk("valid", sch_valid, ev);
    chk("clr", sch_clr, m_phase == 1);
    chk("pos", sch_pos, ev ? m_pos : 0);
    chk("mask", sch_msg_mask, emask);
    chk("cnt", sch_msg_cnt, ecnt);
    chk("sop", sch_sop, esop);
    chk("sop_lane", sch_sop_lane, eslane);
    chk("eop", sch_eop, eeop);
    chk("eop_lane", sch_eop_lane, eelane);
`ifdef ENC_SCH_CNT_EN
    chk("cw_cnt", sch_cw_cnt, m_cnt);
`endif
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0;
      m_pos = 0;
      m_cnt = 0;
    end else begin
      if (m_phase == 1) m_cnt = 0;
      if (m_phase == 2 && sch_ready) begin
        if (has_eop(m_pos)) m_cnt = (m_cnt + 1) % 65536;
        m_pos = (m_pos + S) % N;
      end
      if (m_phase < 2) m_phase++;
    end
    @(negedge clk);
    check_all();
  endtask
  initial begin
    rst_n = 1'b0;
    sch_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rel_valid", sch_valid, 0);
    chk("rel_clr", sch_clr, 0);
    tick();
    chk("pre_clr", sch_clr, 1);
    chk("pre_valid", sch_valid, 0);
    tick();
    chk("first_valid", sch_valid, 1);
    chk("first_mask", sch_msg_mask, 4'b1111);
    chk("first_cnt", sch_msg_cnt, 4);
    chk("first_sop", {sch_sop, sch_sop_lane}, 3'b100);
    for (int b = 0; b < 60; b++) begin
      chk("seq_pos", sch_pos, seq[b % 15]);
      if (seq[b % 15] == 8) begin
        chk("p8_mask", sch_msg_mask, 4'b0111);
        chk("p8_eop", sch_eop, 0);
      end
      if (seq[b % 15] == 12) begin
        chk("p12_mask", sch_msg_mask, 4'b1000);
        chk("p12_eop", {sch_eop, sch_eop_lane}, 3'b110);
        chk("p12_sop", {sch_sop, sch_sop_lane}, 3'b111);
      end
      if (seq[b % 15] == 11) begin
        chk("p11_cnt", sch_msg_cnt, 0);
        chk("p11_eop", {sch_eop, sch_eop_lane}, 3'b111);
        chk("p11_sop", sch_sop, 0);
      end
      tick();
    end
    chk("wrap_pos", sch_pos, 0);
`ifdef ENC_SCH_CNT_EN
    chk("cw_cnt60", sch_cw_cnt, 16);
`endif
    repeat (3) tick();
    chk("stall_start", sch_pos, 12);
    sch_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_pos", sch_pos, 12);
      chk("stall_mask", sch_msg_mask, 4'b1000);
      chk("stall_valid", sch_valid, 1);
    end
    sch_ready = 1'b1;
    tick();
    chk("after_stall", sch_pos, 1);
    for (int c = 0; c < 400; c++) begin
      sch_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 99) != 0;
      tick();
    end
    rst_n = 1'b1;
    sch_ready = 1'b1;
    for (int t = 0; t < 40 && !(m_phase == 2 && m_pos == 9); t++) tick();
    chk("reach9", sch_pos, 9);
    rst_n = 1'b0;
    tick();
    chk("rst_valid", sch_valid, 0);
    chk("rst_pos", sch_pos, 0);
    chk("rst_mask", sch_msg_mask, 0);
    rst_n = 1'b1;
    tick();
    chk("rerun_clr", sch_clr, 1);
`ifdef ENC_SCH_CNT_EN
    chk("rerun_cw_cnt", sch_cw_cnt, 0);
`endif
    tick();
    chk("rerun_pos", {sch_valid, sch_pos}, 5'b10000);
    chk("rerun_sop", {sch_sop, sch_sop_lane}, 3'b100);
    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
